// File: rtl/cam_pkg.sv
// Shared types and constants for the camera capture/pack stage.
// Used by the interface and the cam_pixel_pack top.
package cam_pkg;

    localparam int RGB_W       = 16;
    localparam int COORD_W     = 11;
    localparam int DEF_H_PIXEL = 640;
    localparam int DEF_V_PIXEL = 480;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RUN  = 2'd2
    } cap_state_t;

    // Coordinate counters stick at all-ones instead of wrapping.
    function automatic logic [COORD_W-1:0] sat_inc(input logic [COORD_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/cam_pixel_pack_if.sv
// Sensor DVP inputs and packed-pixel outputs of the capture stage.
// master = capture stage, slave = sensor model / downstream consumer.
interface cam_pixel_pack_if;
    import cam_pkg::*;

    logic               cam_vsync;
    logic               cam_href;
    logic [7:0]         cam_data;

    logic               frame_vsync;
    logic               frame_href;
    logic               frame_valid;
    logic [RGB_W-1:0]   frame_data;
    logic [COORD_W-1:0] xpos;
    logic [COORD_W-1:0] ypos;
    logic               frame_done;
    logic               size_err;

    modport master (
        input  cam_vsync, cam_href, cam_data,
        output frame_vsync, frame_href, frame_valid, frame_data,
               xpos, ypos, frame_done, size_err
    );

    modport slave (
        output cam_vsync, cam_href, cam_data,
        input  frame_vsync, frame_href, frame_valid, frame_data,
               xpos, ypos, frame_done, size_err
    );

endinterface

// File: rtl/cam_sync_edge.sv
// Registers the raw DVP inputs once and derives the vsync rising edge
// and href falling edge from the registered copies.
module cam_sync_edge (
    input  logic       clk,
    input  logic       rst,
    input  logic       cam_vsync,
    input  logic       cam_href,
    input  logic [7:0] cam_data,
    output logic       vsync_d0,
    output logic       href_d0,
    output logic [7:0] data_d0,
    output logic       vs_rise,
    output logic       href_fall
);

    logic vsync_d1;
    logic href_d1;

    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_d0 <= 1'b0;
            vsync_d1 <= 1'b0;
            href_d0  <= 1'b0;
            href_d1  <= 1'b0;
            data_d0  <= 8'h00;
        end else begin
            vsync_d0 <= cam_vsync;
            vsync_d1 <= vsync_d0;
            href_d0  <= cam_href;
            href_d1  <= href_d0;
            data_d0  <= cam_data;
        end
    end

    assign vs_rise   = vsync_d0 & ~vsync_d1;
    assign href_fall = ~href_d0 & href_d1;

endmodule

// File: rtl/cam_pixel_pack.sv
// OV5640 DVP capture: skips the settling frames after capture_start, then
// packs byte pairs into RGB565 pixels with coordinates and a geometry check.
//
// state | meaning
// IDLE  | capture not allowed, counter cleared
// WAIT  | counting vsync rising edges while the sensor settles
// RUN   | output enabled until rst
module cam_pixel_pack
    import cam_pkg::*;
#(
    parameter int WAIT_FRAMES = 10,
    parameter int H_PIXEL     = DEF_H_PIXEL,
    parameter int V_PIXEL     = DEF_V_PIXEL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             capture_start,
    cam_pixel_pack_if.master bus
);

    localparam logic [3:0]         WAIT_TC = 4'(WAIT_FRAMES);
    localparam logic [COORD_W-1:0] H_TC    = COORD_W'(H_PIXEL);
    localparam logic [COORD_W-1:0] V_TC    = COORD_W'(V_PIXEL);

    logic       vsync_d0;
    logic       href_d0;
    logic [7:0] data_d0;
    logic       vs_rise;
    logic       href_fall;

    cam_sync_edge u_sync (
        .clk       (clk),
        .rst       (rst),
        .cam_vsync (bus.cam_vsync),
        .cam_href  (bus.cam_href),
        .cam_data  (bus.cam_data),
        .vsync_d0  (vsync_d0),
        .href_d0   (href_d0),
        .data_d0   (data_d0),
        .vs_rise   (vs_rise),
        .href_fall (href_fall)
    );

    cap_state_t state;
    cap_state_t state_nx;
    logic [3:0] wait_cnt;
    logic [3:0] wait_cnt_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_cnt_nx;
        end
    end

    // The vs_rise that finds the counter already at WAIT_FRAMES opens frame 0.
    always_comb begin
        state_nx    = state;
        wait_cnt_nx = wait_cnt;
        unique case (state)
            IDLE: begin
                if (capture_start) state_nx = WAIT;
            end
            WAIT: begin
                if (!capture_start) begin
                    state_nx    = IDLE;
                    wait_cnt_nx = 4'd0;
                end else if (vs_rise) begin
                    if (wait_cnt == WAIT_TC) state_nx = RUN;
                    else                     wait_cnt_nx = wait_cnt + 4'd1;
                end
            end
            RUN: begin
                state_nx = RUN;
            end
            default: begin
                state_nx    = IDLE;
                wait_cnt_nx = 4'd0;
            end
        endcase
    end

    logic               run;
    logic               toggle;
    logic               pix_ready;
    logic [7:0]         hi_byte;
    logic [COORD_W-1:0] x_cnt;
    logic [COORD_W-1:0] y_cnt;
    logic [COORD_W-1:0] lines_seen;
    logic               line_bad;
    logic               frame_bad;

    logic               valid_q;
    logic [RGB_W-1:0]   data_q;
    logic [COORD_W-1:0] xpos_q;
    logic [COORD_W-1:0] ypos_q;
    logic               done_q;
    logic               err_q;

    assign run       = (state == RUN);
    assign pix_ready = href_d0 & toggle;

    // A line ending on the same cycle as vs_rise still counts toward the frame.
    assign lines_seen = href_fall ? sat_inc(y_cnt) : y_cnt;
    assign line_bad   = href_fall & ((x_cnt != H_TC) | toggle);
    assign frame_bad  = vs_rise & (lines_seen != V_TC);

    always_ff @(posedge clk) begin
        if (rst) begin
            toggle  <= 1'b0;
            hi_byte <= 8'h00;
            x_cnt   <= '0;
            y_cnt   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            xpos_q  <= '0;
            ypos_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            toggle <= href_d0 ? ~toggle : 1'b0;
            if (href_d0 && !toggle) hi_byte <= data_d0;

            valid_q <= run & pix_ready;
            if (run && pix_ready) begin
                data_q <= {hi_byte, data_d0};
                xpos_q <= x_cnt;
                ypos_q <= y_cnt;
            end

            if (href_fall)      x_cnt <= '0;
            else if (pix_ready) x_cnt <= sat_inc(x_cnt);

            if (vs_rise)        y_cnt <= '0;
            else if (href_fall) y_cnt <= sat_inc(y_cnt);

            // State is still WAIT on the vs_rise that opens frame 0, so that
            // edge neither pulses frame_done nor checks a line count.
            done_q <= run & vs_rise;
            if (run && (line_bad || frame_bad)) err_q <= 1'b1;
        end
    end

    assign bus.frame_vsync = run & vsync_d0;
    assign bus.frame_href  = run & href_d0;
    assign bus.frame_valid = valid_q;
    assign bus.frame_data  = data_q;
    assign bus.xpos        = xpos_q;
    assign bus.ypos        = ypos_q;
    assign bus.frame_done  = done_q;
    assign bus.size_err    = err_q;

endmodule
